// File: rtl/date_setter.sv
// rtl/date_setter.sv - front-panel BCD date editor with debounced mode/inc buttons and a one-cycle load strobe
module date_setter #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_value0,
  input  logic [3:0] cur_value1,
  input  logic [3:0] cur_value2,
  input  logic [3:0] cur_value3,
  input  logic [3:0] cur_value4,
  input  logic [3:0] cur_value5,
  output logic [3:0] set_value0,
  output logic [3:0] set_value1,
  output logic [3:0] set_value2,
  output logic [3:0] set_value3,
  output logic [3:0] set_value4,
  output logic [3:0] set_value5,
  output logic       load,
  output logic       editing,
  output logic [1:0] field
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SET_YEAR  = 2'b01,
    SET_MONTH = 2'b10,
    SET_DAY   = 2'b11
  } state_t;

  state_t state, state_n;

  logic [1:0]    raw, sync1, sync2, acc, pulse;
  logic [CW-1:0] cnt [2];
  logic          mode_p, inc_p;

  logic [7:0] year_q, mon_q, day_q;
  logic [7:0] year_n, mon_n, day_n, day_max, day_fix, cur_mon;

  assign raw    = {btn_inc, btn_mode};
  assign mode_p = pulse[0];
  assign inc_p  = pulse[1];

  // Both buttons share one debouncer body; the pulse rises in the same edge the level is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      pulse <= '0;
      for (int b = 0; b < 2; b++) cnt[b] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int b = 0; b < 2; b++) begin
        pulse[b] <= 1'b0;
        if (sync2[b] == acc[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CW'(DEB_CYCLES - 1)) begin
          cnt[b]   <= '0;
          acc[b]   <= sync2[b];
          pulse[b] <= sync2[b];
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  function automatic logic is_leap(input logic [7:0] y);
    if (!y[4]) return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
    else       return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
  endfunction

  function automatic logic [7:0] max_day(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic valid_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (mode_p) begin
      case (state)
        IDLE:      state_n = SET_YEAR;
        SET_YEAR:  state_n = SET_MONTH;
        SET_MONTH: state_n = SET_DAY;
        default:   state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    editing = (state != IDLE);
    field   = state;
  end

  // Every path into the edit registers goes through the same day clamp, so
  // captures and year/month changes never leave an impossible date behind.
  always_comb begin
    cur_mon = {cur_value3, cur_value2};
    year_n  = year_q;
    mon_n   = mon_q;
    day_n   = day_q;
    if (state == IDLE) begin
      if (mode_p) begin
        year_n = {cur_value5, cur_value4};
        mon_n  = (valid_bcd(cur_mon) && cur_mon != 8'h00 && cur_mon <= 8'h12) ? cur_mon : 8'h01;
        day_n  = {cur_value1, cur_value0};
      end
    end else if (inc_p && !mode_p) begin
      case (state)
        SET_YEAR:  year_n = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
        SET_MONTH: mon_n  = (mon_q >= 8'h12) ? 8'h01 : bcd_inc(mon_q);
        SET_DAY:   day_n  = (day_q >= max_day(mon_q, year_q)) ? 8'h01 : bcd_inc(day_q);
        default:   ;
      endcase
    end
    day_max = max_day(mon_n, year_n);
    if (!valid_bcd(day_n) || day_n == 8'h00) day_fix = 8'h01;
    else if (day_n > day_max)                day_fix = day_max;
    else                                     day_fix = day_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year_q <= 8'h00;
      mon_q  <= 8'h01;
      day_q  <= 8'h01;
      load   <= 1'b0;
    end else begin
      year_q <= year_n;
      mon_q  <= mon_n;
      day_q  <= day_fix;
      load   <= (state == SET_DAY) && mode_p;
    end
  end

  assign set_value0 = day_q[3:0];
  assign set_value1 = day_q[7:4];
  assign set_value2 = mon_q[3:0];
  assign set_value3 = mon_q[7:4];
  assign set_value4 = year_q[3:0];
  assign set_value5 = year_q[7:4];

endmodule

// File: tb/tb_date_setter.sv
// tb/tb_date_setter.sv - scoreboard bench for date_setter
module tb_date_setter;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_value0, cur_value1, cur_value2, cur_value3, cur_value4, cur_value5;
  logic [3:0] set_value0, set_value1, set_value2, set_value3, set_value4, set_value5;
  logic       load, editing;
  logic [1:0] field;
  logic [23:0] date_now;

  date_setter #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_value0(cur_value0), .cur_value1(cur_value1), .cur_value2(cur_value2),
    .cur_value3(cur_value3), .cur_value4(cur_value4), .cur_value5(cur_value5),
    .set_value0(set_value0), .set_value1(set_value1), .set_value2(set_value2),
    .set_value3(set_value3), .set_value4(set_value4), .set_value5(set_value5),
    .load(load), .editing(editing), .field(field)
  );

  always #5 clk = ~clk;

  assign date_now = {set_value5, set_value4, set_value3, set_value2, set_value1, set_value0};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  fld;
    logic        edit;
    logic [23:0] date;
  } snap_t;

  snap_t exp_q[$];

  task automatic expect_st(input logic [1:0] f, input logic [7:0] yy, input logic [7:0] mm, input logic [7:0] dd);
    exp_q.push_back({f, (f != 2'b00), yy, mm, dd});
  endtask

  task automatic check_st(input string tag);
    snap_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_date"}, {8'h00, date_now}, {8'h00, e.date});
      check({tag, "_field"}, {30'd0, field}, {30'd0, e.fld});
      check({tag, "_edit"}, {31'd0, editing}, {31'd0, e.edit});
    end
  endtask

  task automatic set_cur(input logic [7:0] dd, input logic [7:0] mm, input logic [7:0] yy);
    cur_value0 = dd[3:0]; cur_value1 = dd[7:4];
    cur_value2 = mm[3:0]; cur_value3 = mm[7:4];
    cur_value4 = yy[3:0]; cur_value5 = yy[7:4];
  endtask

  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  int          load_cnt = 0;
  int          load_run = 0;
  int          load_run_max = 0;
  logic [23:0] load_date = '0;

  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      load_run++;
      if (load_run > load_run_max) load_run_max = load_run;
      load_date = date_now;
    end else begin
      load_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    set_cur(8'h31, 8'h12, 8'h99);
    repeat (3) @(negedge clk);
    expect_st(2'd0, 8'h00, 8'h01, 8'h01);
    check_st("reset");
    check("reset_load", {31'd0, load}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    expect_st(2'd1, 8'h99, 8'h12, 8'h31);
    btn_mode = 1'b1;
    n = 0;
    while (!editing && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("entry_latency", {31'd0, editing}, 32'd1);
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check_st("entry");

    expect_st(2'd1, 8'h00, 8'h12, 8'h31); press(1'b0, 1'b1); check_st("year_wrap");
    expect_st(2'd2, 8'h00, 8'h12, 8'h31); press(1'b1, 1'b0); check_st("to_month");
    expect_st(2'd2, 8'h00, 8'h01, 8'h31); press(1'b0, 1'b1); check_st("month_wrap");
    expect_st(2'd3, 8'h00, 8'h01, 8'h31); press(1'b1, 1'b0); check_st("to_day");
    expect_st(2'd0, 8'h00, 8'h01, 8'h31); press(1'b1, 1'b0); check_st("commit");
    check("commit_load_cnt", load_cnt, 32'd1);
    check("load_width", load_run_max, 32'd1);
    check("load_date", {8'h00, load_date}, 32'h00_0131);

    set_cur(8'h31, 8'h03, 8'h01);
    expect_st(2'd1, 8'h01, 8'h03, 8'h31); press(1'b1, 1'b0); check_st("recap_mar");
    expect_st(2'd2, 8'h01, 8'h03, 8'h31); press(1'b1, 1'b0); check_st("to_month2");
    expect_st(2'd2, 8'h01, 8'h04, 8'h30); press(1'b0, 1'b1); check_st("clamp_apr");
    for (int k = 0; k < 10; k++) press(1'b0, 1'b1);
    expect_st(2'd2, 8'h01, 8'h02, 8'h28); check_st("clamp_feb");
    expect_st(2'd3, 8'h01, 8'h02, 8'h28); press(1'b1, 1'b0); check_st("to_day2");
    expect_st(2'd0, 8'h01, 8'h02, 8'h28); press(1'b1, 1'b0); check_st("commit2");
    check("commit2_load_cnt", load_cnt, 32'd2);

    set_cur(8'h28, 8'h02, 8'h01);
    expect_st(2'd1, 8'h01, 8'h02, 8'h28); press(1'b1, 1'b0); check_st("recap_feb");
    for (int y = 2; y <= 4; y++) begin
      expect_st(2'd1, 8'(y), 8'h02, 8'h28);
      press(1'b0, 1'b1);
      check_st("year_up");
    end
    press(1'b1, 1'b0);
    expect_st(2'd3, 8'h04, 8'h02, 8'h28); press(1'b1, 1'b0); check_st("leap_day");
    expect_st(2'd3, 8'h04, 8'h02, 8'h29); press(1'b0, 1'b1); check_st("leap_29");
    expect_st(2'd3, 8'h04, 8'h02, 8'h01); press(1'b0, 1'b1); check_st("leap_wrap");

    expect_st(2'd3, 8'h04, 8'h02, 8'h01);
    for (int k = 0; k < 10; k++) begin
      btn_inc = ~btn_inc;
      repeat (2) @(negedge clk);
    end
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check_st("bounce");
    expect_st(2'd3, 8'h04, 8'h02, 8'h02); press(1'b0, 1'b1); check_st("clean_hold");
    expect_st(2'd0, 8'h04, 8'h02, 8'h02); press(1'b1, 1'b0); check_st("commit3");
    check("commit3_load_cnt", load_cnt, 32'd3);

    set_cur(8'h15, 8'h06, 8'h07);
    expect_st(2'd1, 8'h07, 8'h06, 8'h15); press(1'b1, 1'b0); check_st("recap_jun");
    expect_st(2'd2, 8'h07, 8'h06, 8'h15); press(1'b1, 1'b1); check_st("mode_wins");

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_st(2'd0, 8'h00, 8'h01, 8'h01); check_st("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_st(2'd0, 8'h00, 8'h01, 8'h01); check_st("post_reset");
    check("reset_no_load", load_cnt, 32'd3);

    set_cur(8'h30, 8'h02, 8'h03);
    expect_st(2'd1, 8'h03, 8'h02, 8'h28); press(1'b1, 1'b0); check_st("recap_clamp");
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    expect_st(2'd0, 8'h03, 8'h02, 8'h28); press(1'b1, 1'b0); check_st("commit4");
    set_cur(8'h31, 8'h13, 8'h05);
    expect_st(2'd1, 8'h05, 8'h01, 8'h31); press(1'b1, 1'b0); check_st("bad_month");
    check("final_load_cnt", load_cnt, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
